fc_head: RTL and testbench
==========================

Name: fc_head

Overview:
- Consumer end of the LSTM hidden-state output stream (h_to_full_en / h_to_full).
- Accepts IN_NUM hidden values serially and computes OUT_NUM fully-connected outputs in parallel multiply-accumulate lanes.
- Adds bias, then rescales and saturates each lane to D_WL.
- Streams the OUT_NUM scores out one per cycle, then reports the argmax class for keyword decision.

Parameters:
- IN_NUM, 30, hidden values per inference (equals ALL_CELL_NUM of the LSTM).
- OUT_NUM, 12, number of output classes / parallel MAC lanes.
- D_WL, 24, data word length, signed two's complement.
- FL, 14, fractional bits of all data, weights and bias.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- h_in_en  in  1  hidden value valid, one value per cycle while high.
- h_in  in  D_WL  hidden value.
- w_addr  out  8  weight ROM address; equals current input index.
- w_data  in  D_WL*OUT_NUM  weights for w_addr, combinational ROM; lane j at bits [j*D_WL +: D_WL].
- b_data  in  D_WL*OUT_NUM  bias per lane, static.
- y_valid  out  1  score output valid.
- y_idx  out  8  class index of y_data.
- y_data  out  D_WL  saturated score.
- class_valid  out  1  one-cycle pulse, argmax ready.
- class_idx  out  8  argmax class index.
- busy  out  1  high in any state other than ACC with cnt==0.
- err_drop  out  1  sticky flag, set when h_in_en is high outside ACC; cleared only by reset.

Behaviour:
- Reset: all outputs 0; state ACC; cnt=0; accumulators 0; max register = most negative value.
- Accumulator width AW = 2*D_WL + 8, signed. Products are full 2*D_WL signed, sign-extended to AW; no rounding during accumulation.
- w_addr = cnt (combinational from the counter register). w_data is sampled in the same cycle as h_in.
- ACC state:
  - Each cycle with h_in_en: acc[j] += h_in * w_data[j] for every lane j; cnt++.
  - On the beat where cnt==IN_NUM-1, go to BIAS and set cnt=0.
  - Cycles without h_in_en hold all state.
- BIAS state (1 cycle): acc[j] += sign_ext(b_data[j]) << FL, then go to OUT.
- OUT state (OUT_NUM cycles, k = 0..OUT_NUM-1):
  - Registered outputs: y_valid=1, y_idx=k, y_data=sat(acc[k] >>> FL).
  - Shift is arithmetic (floor toward -inf).
  - sat clamps to [-2^(D_WL-1), 2^(D_WL-1)-1].
  - Max tracking: replace the max only when the score is strictly greater, so ties go to the lowest index.
  - After k==OUT_NUM-1, go to DONE.
- DONE state (1 cycle): class_valid=1, class_idx=argmax. Then clear accumulators, reset max, go to ACC.
- Latency: if the last h beat is sampled at edge T, outputs are:
  - y_valid high for the cycles after edges T+2 .. T+1+OUT_NUM;
  - class_valid high for the cycle after edge T+2+OUT_NUM.
- h_in_en outside ACC: the value is dropped, err_drop is set, and results are unaffected.
- Back-to-back inferences: h_in_en is accepted again from the first cycle back in ACC.
- Asynchronous reset mid-operation: immediate return to the reset state; partial accumulation is discarded.
- Output cleanliness: y_valid and class_valid are 0 in all other cycles; y_data, y_idx and class_idx hold their last value.

Test Plan:
- Reset, then 30 beats of h=16384 with w[j]=1024*j and bias 0 -> y_data[j]=30720*j for j=0..11; class_idx=11; class_valid exactly OUT_NUM+2 cycles after the last beat.
- Same weights, h valid with one-cycle gaps every other beat -> identical outputs; latency counted from the last beat.
- h=4194304 (256.0), w=4194304, lane 0 only -> y_data[0]=8388607 (saturated). Same case with w=-4194304 -> -8388608.
- h beat0=-1 (1 LSB), w=1 LSB, all other h=0, bias 0 -> y_data[0]=-1 (floor). Bias 16384 on lane 3 with h all zero -> y_data[3]=16384.
- All weights 0, bias[2]=bias[5]=100, others 0 -> class_idx=2 (tie resolves to the lowest index).
- h_in_en asserted during OUT -> err_drop=1 and scores unchanged. rst_n low at beat 15 -> outputs 0; a following full 30-beat inference gives clean results.

Source files
------------

// File: rtl/fc_head.sv
// fc_head: fully-connected classifier head at the consumer end of the LSTM
// hidden-state stream.
//
// It takes IN_NUM hidden values one at a time and runs OUT_NUM multiply-
// accumulate lanes in parallel. It then adds a bias to every lane, rescales
// each lane by FL and saturates it to D_WL bits. The OUT_NUM scores leave one
// per cycle, and a final one-cycle pulse reports the argmax class.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   h_in_en      hidden value valid (one value per cycle while high)
//   h_in         hidden value, signed Q(D_WL-FL).FL
//   w_addr       weight ROM address (= current input index)
//   w_data       OUT_NUM weights for w_addr, lane j at [j*D_WL +: D_WL]
//   b_data       static per-lane bias, same packing as w_data
//   y_valid      score valid
//   y_idx        class index of y_data
//   y_data       saturated score
//   class_valid  one-cycle pulse, argmax ready
//   class_idx    argmax class index
//   busy         high unless idle (ACC state with no partial input)
//   err_drop     sticky: a hidden value arrived outside ACC and was dropped

// One MAC lane: a wide accumulator that can be loaded with products or bias.
module fc_lane #(
  parameter int D_WL = 24,
  parameter int FL   = 14,
  parameter int AW   = 2*D_WL + 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mac_en_i,
  input  logic                   bias_en_i,
  input  logic                   clr_i,
  input  logic signed [D_WL-1:0] h_i,
  input  logic signed [D_WL-1:0] w_i,
  input  logic signed [D_WL-1:0] b_i,
  output logic signed [AW-1:0]   acc_o
);

  logic signed [2*D_WL-1:0] prod;
  logic signed [AW-1:0]     acc_q, acc_d;

  // Full-precision product; no rounding anywhere in the accumulation.
  assign prod = (2*D_WL)'(h_i) * (2*D_WL)'(w_i);

  always_comb begin
    acc_d = acc_q;
    if (clr_i)
      acc_d = '0;
    else if (bias_en_i)
      // Bias is in the same Q format as the inputs, while the accumulator
      // holds products with 2*FL fractional bits. Align it by shifting left FL.
      acc_d = acc_q + (AW'(b_i) <<< FL);
    else if (mac_en_i)
      acc_d = acc_q + AW'(prod);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

module fc_head #(
  parameter int IN_NUM  = 30,
  parameter int OUT_NUM = 12,
  parameter int D_WL    = 24,
  parameter int FL      = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    h_in_en,
  input  logic [D_WL-1:0]         h_in,
  output logic [7:0]              w_addr,
  input  logic [D_WL*OUT_NUM-1:0] w_data,
  input  logic [D_WL*OUT_NUM-1:0] b_data,
  output logic                    y_valid,
  output logic [7:0]              y_idx,
  output logic [D_WL-1:0]         y_data,
  output logic                    class_valid,
  output logic [7:0]              class_idx,
  output logic                    busy,
  output logic                    err_drop
);

  localparam int AW = 2*D_WL + 8;
  localparam int HW = AW - D_WL + 1;  // bits that must agree for no overflow

  localparam logic [D_WL-1:0] SMAX = {1'b0, {(D_WL-1){1'b1}}};
  localparam logic [D_WL-1:0] SMIN = {1'b1, {(D_WL-1){1'b0}}};

  typedef enum logic [1:0] {ST_ACC, ST_BIAS, ST_OUT, ST_DONE} state_e;

  state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic                   y_valid_q, y_valid_d;
  logic [7:0]             y_idx_q, y_idx_d;
  logic [D_WL-1:0]        y_data_q, y_data_d;
  logic                   class_valid_q, class_valid_d;
  logic [7:0]             class_idx_q, class_idx_d;
  logic                   err_q, err_d;
  logic signed [D_WL-1:0] max_q, max_d;
  logic [7:0]             arg_q, arg_d;

  logic mac_en, bias_en, clr;
  logic [OUT_NUM-1:0][AW-1:0] acc;

  // ---------------------------------------------------------------------
  // MAC lanes
  // ---------------------------------------------------------------------
  assign mac_en  = (state_q == ST_ACC) && h_in_en;
  assign bias_en = (state_q == ST_BIAS);
  assign clr     = (state_q == ST_DONE);

  for (genvar j = 0; j < OUT_NUM; j++) begin : g_lane
    fc_lane #(.D_WL(D_WL), .FL(FL), .AW(AW)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .mac_en_i  (mac_en),
      .bias_en_i (bias_en),
      .clr_i     (clr),
      .h_i       ($signed(h_in)),
      .w_i       ($signed(w_data[j*D_WL +: D_WL])),
      .b_i       ($signed(b_data[j*D_WL +: D_WL])),
      .acc_o     (acc[j])
    );
  end

  // ---------------------------------------------------------------------
  // Score of lane cnt_q: arithmetic rescale followed by saturation
  // ---------------------------------------------------------------------
  logic signed [AW-1:0]   sel_acc;
  logic signed [AW-1:0]   sh;
  logic [HW-1:0]          hi;
  logic signed [D_WL-1:0] score;

  always_comb begin
    sel_acc = '0;
    for (int j = 0; j < OUT_NUM; j++)
      if (cnt_q == 8'(j)) sel_acc = $signed(acc[j]);
  end

  assign sh = sel_acc >>> FL;  // floor toward -inf
  assign hi = sh[AW-1:D_WL-1];

  always_comb begin
    // The value fits in D_WL bits only when the top bits are a pure sign extension.
    if ((&hi) || (~|hi)) score = sh[D_WL-1:0];
    else if (sh[AW-1])   score = SMIN;
    else                 score = SMAX;
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_ACC: begin
        if (h_in_en) begin
          if (cnt_q == 8'(IN_NUM-1)) begin
            cnt_d   = '0;
            state_d = ST_BIAS;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_BIAS: state_d = ST_OUT;
      ST_OUT: begin
        // cnt_q doubles as the output lane index here.
        if (cnt_q == 8'(OUT_NUM-1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_ACC;
      default: state_d = ST_ACC;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output registers and argmax tracking
  // ---------------------------------------------------------------------
  always_comb begin
    y_valid_d     = 1'b0;
    y_idx_d       = y_idx_q;
    y_data_d      = y_data_q;
    class_valid_d = 1'b0;
    class_idx_d   = class_idx_q;
    max_d         = max_q;
    arg_d         = arg_q;
    err_d         = err_q | (h_in_en && (state_q != ST_ACC));
    unique case (state_q)
      ST_OUT: begin
        y_valid_d = 1'b1;
        y_idx_d   = cnt_q;
        y_data_d  = score;
        // Strictly greater, so a tie keeps the lower index.
        if (score > max_q) begin
          max_d = score;
          arg_d = cnt_q;
        end
      end
      ST_DONE: begin
        class_valid_d = 1'b1;
        class_idx_d   = arg_q;
        max_d         = SMIN;
        arg_d         = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_ACC;
      cnt_q         <= '0;
      y_valid_q     <= 1'b0;
      y_idx_q       <= '0;
      y_data_q      <= '0;
      class_valid_q <= 1'b0;
      class_idx_q   <= '0;
      err_q         <= 1'b0;
      max_q         <= SMIN;
      arg_q         <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      y_valid_q     <= y_valid_d;
      y_idx_q       <= y_idx_d;
      y_data_q      <= y_data_d;
      class_valid_q <= class_valid_d;
      class_idx_q   <= class_idx_d;
      err_q         <= err_d;
      max_q         <= max_d;
      arg_q         <= arg_d;
    end
  end

  assign w_addr      = cnt_q;
  assign y_valid     = y_valid_q;
  assign y_idx       = y_idx_q;
  assign y_data      = y_data_q;
  assign class_valid = class_valid_q;
  assign class_idx   = class_idx_q;
  assign err_drop    = err_q;
  assign busy        = (state_q != ST_ACC) || (cnt_q != 8'd0);

endmodule

// File: tb/tb_fc_head.sv
// Scoreboard bench for fc_head: the expected scores, argmax and output cycles
// are queued when the last beat is driven and checked as the DUT emits them.
module tb_fc_head;

  localparam int IN_NUM  = 30;
  localparam int OUT_NUM = 12;
  localparam int D_WL    = 24;
  localparam int FL      = 14;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    h_in_en = 1'b0;
  logic [D_WL-1:0]         h_in = '0;
  logic [7:0]              w_addr;
  logic [D_WL*OUT_NUM-1:0] w_data;
  logic [D_WL*OUT_NUM-1:0] b_data = '0;
  logic                    y_valid;
  logic [7:0]              y_idx;
  logic [D_WL-1:0]         y_data;
  logic                    class_valid;
  logic [7:0]              class_idx;
  logic                    busy;
  logic                    err_drop;

  fc_head #(.IN_NUM(IN_NUM), .OUT_NUM(OUT_NUM), .D_WL(D_WL), .FL(FL)) dut (
    .clk(clk), .rst_n(rst_n), .h_in_en(h_in_en), .h_in(h_in), .w_addr(w_addr),
    .w_data(w_data), .b_data(b_data), .y_valid(y_valid), .y_idx(y_idx),
    .y_data(y_data), .class_valid(class_valid), .class_idx(class_idx),
    .busy(busy), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  // Combinational weight ROM
  logic [D_WL*OUT_NUM-1:0] wrom [IN_NUM];
  assign w_data = (w_addr < 8'(IN_NUM)) ? wrom[w_addr] : '0;

  int hv [IN_NUM];
  int wv [IN_NUM][OUT_NUM];
  int bv [OUT_NUM];

  typedef struct {int idx; longint data; int cyc;} exp_t;
  exp_t yq[$];
  exp_t cq[$];

  int cyc = 0;
  int done_cnt = 0;
  int n_vec = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor / scoreboard pop
  always @(negedge clk) begin
    if (rst_n && y_valid) begin
      if (yq.size() == 0) chk("y_spurious", 1, 0);
      else begin
        exp_t e;
        e = yq.pop_front();
        chk("y_idx", y_idx, e.idx);
        chk("y_data", $signed(y_data), e.data);
        chk("y_latency", cyc, e.cyc);
      end
    end
    if (rst_n && class_valid) begin
      if (cq.size() == 0) chk("class_spurious", 1, 0);
      else begin
        exp_t e;
        e = cq.pop_front();
        chk("class_idx", class_idx, e.idx);
        chk("class_latency", cyc, e.cyc);
      end
      done_cnt++;
    end
  end

  task automatic clr_stim();
    for (int i = 0; i < IN_NUM; i++) begin
      hv[i] = 0;
      for (int j = 0; j < OUT_NUM; j++) wv[i][j] = 0;
    end
    for (int j = 0; j < OUT_NUM; j++) bv[j] = 0;
  endtask

  task automatic load();
    for (int i = 0; i < IN_NUM; i++)
      for (int j = 0; j < OUT_NUM; j++) wrom[i][j*D_WL +: D_WL] = D_WL'(wv[i][j]);
    for (int j = 0; j < OUT_NUM; j++) b_data[j*D_WL +: D_WL] = D_WL'(bv[j]);
  endtask

  // Reference model: exact integer math, floor shift, clamp, first-max argmax.
  task automatic push_exp(input int last);
    longint acc, s, best;
    int arg;
    best = -(longint'(1) <<< (D_WL-1));
    arg  = 0;
    for (int j = 0; j < OUT_NUM; j++) begin
      acc = 0;
      for (int i = 0; i < IN_NUM; i++) acc += longint'(hv[i]) * longint'(wv[i][j]);
      acc += longint'(bv[j]) <<< FL;
      s = acc >>> FL;
      if (s > (longint'(1) <<< (D_WL-1)) - 1) s = (longint'(1) <<< (D_WL-1)) - 1;
      if (s < -(longint'(1) <<< (D_WL-1)))    s = -(longint'(1) <<< (D_WL-1));
      yq.push_back('{j, s, last + 2 + j});
      if (s > best) begin best = s; arg = j; end
    end
    cq.push_back('{arg, 0, last + 2 + OUT_NUM});
  endtask

  task automatic run_inf(input bit gap, input bit inj);
    int start;
    start = done_cnt;
    load();
    for (int i = 0; i < IN_NUM; i++) begin
      if (gap && (i % 2 == 1)) begin
        @(negedge clk); h_in_en = 1'b0; h_in = D_WL'($urandom);
      end
      @(negedge clk); h_in_en = 1'b1; h_in = D_WL'(hv[i]);
      if (i == IN_NUM-1) push_exp(cyc + 1);
    end
    @(negedge clk); h_in_en = 1'b0;
    if (inj) begin
      repeat (3) @(negedge clk);
      chk("busy_out", busy, 1);
      h_in_en = 1'b1; h_in = D_WL'($urandom);
      @(negedge clk); h_in_en = 1'b0;
    end
    for (int c = 0; c < 100 && done_cnt == start; c++) @(negedge clk);
    if (done_cnt == start) chk("class_timeout", 0, 1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_y_valid"}, y_valid, 0);
    chk({tag, "_y_data"}, y_data, 0);
    chk({tag, "_y_idx"}, y_idx, 0);
    chk({tag, "_class_valid"}, class_valid, 0);
    chk({tag, "_class_idx"}, class_idx, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err_drop"}, err_drop, 0);
    chk({tag, "_w_addr"}, w_addr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_stim();
    load();
    repeat (3) @(negedge clk);
    chk_reset_state("rst");
    rst_n = 1'b1;

    // 1: ramp weights, h = 1.0 -> 30720*j, class 11
    clr_stim();
    for (int i = 0; i < IN_NUM; i++) begin
      hv[i] = 16384;
      for (int j = 0; j < OUT_NUM; j++) wv[i][j] = 1024 * j;
    end
    run_inf(1'b0, 1'b0);

    // 2: same with gaps between beats
    run_inf(1'b1, 1'b0);

    // 3: positive saturation on lane 0
    clr_stim();
    for (int i = 0; i < IN_NUM; i++) begin hv[i] = 4194304; wv[i][0] = 4194304; end
    run_inf(1'b0, 1'b0);

    // 4: negative saturation on lane 0
    for (int i = 0; i < IN_NUM; i++) wv[i][0] = -4194304;
    run_inf(1'b0, 1'b0);

    // 5: floor of -1 LSB product
    clr_stim();
    hv[0] = -1; wv[0][0] = 1;
    run_inf(1'b0, 1'b0);

    // 6: bias only on lane 3
    clr_stim();
    bv[3] = 16384;
    run_inf(1'b0, 1'b0);

    // 7: tie between lanes 2 and 5
    clr_stim();
    bv[2] = 100; bv[5] = 100;
    run_inf(1'b0, 1'b0);
    chk("err_clean", err_drop, 0);

    // 8: stray h_in_en during OUT is dropped and flagged
    clr_stim();
    for (int i = 0; i < IN_NUM; i++) begin
      hv[i] = 1000 + 37 * i;
      for (int j = 0; j < OUT_NUM; j++) wv[i][j] = (j * 311 - i * 97) * 13;
    end
    for (int j = 0; j < OUT_NUM; j++) bv[j] = 5000 - 900 * j;
    run_inf(1'b0, 1'b1);
    chk("err_set", err_drop, 1);

    // 9: reset at beat 15, then a clean full inference
    clr_stim();
    for (int i = 0; i < IN_NUM; i++) begin
      hv[i] = 16384;
      for (int j = 0; j < OUT_NUM; j++) wv[i][j] = 1024 * j;
    end
    load();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); h_in_en = 1'b1; h_in = D_WL'(hv[i]);
    end
    @(negedge clk); h_in_en = 1'b0;
    chk("busy_partial", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    @(negedge clk); rst_n = 1'b1;
    run_inf(1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("yq_empty", yq.size(), 0);
    chk("cq_empty", cq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
